// File: rtl/blit_write_buffer.sv
// Write-combining buffer: merges blitter byte writes into 32-byte lines, drains each line as an 8-beat SDRAM burst.
// Latency: a handed-off line raises mem_request on the next cycle; the timeout flush fires FLUSH_TIMEOUT+1 cycles after the last write.
// Backpressure: write_stall is combinational; it is raised on flush/flush-pending, or on a line miss while the previous line is still draining.
module blit_write_buffer #(
    parameter int FLUSH_TIMEOUT = 64
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [25:0] write_address,
    input  logic [7:0]  write_data,
    input  logic        write_request,
    output logic        write_stall,
    input  logic        flush,
    output logic        idle,
    output logic [25:0] mem_address,
    output logic        mem_request,
    output logic        mem_write,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_byte_enable,
    input  logic        mem_wready,
    input  logic        mem_ack,
    input  logic        mem_complete
);

    localparam int TW = (FLUSH_TIMEOUT > 0) ? $clog2(FLUSH_TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DATA = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [3:0]            r_beat;
    logic [3:0]            w_beat_nxt;

    logic [20:0]           r_fill_tag;
    logic [7:0][3:0][7:0]  r_fill_data;
    logic [7:0][3:0]       r_fill_mask;

    logic [20:0]           r_flush_tag;
    logic [7:0][3:0][7:0]  r_flush_data;
    logic [7:0][3:0]       r_flush_mask;

    logic                  r_flush_pending;
    logic [TW-1:0]         r_timer;

    logic [2:0]            w_word;
    logic [1:0]            w_lane;
    logic                  w_fill_valid;
    logic                  w_tag_match;
    logic                  w_fsm_idle;
    logic                  w_accept;
    logic                  w_timeout;
    logic                  w_handoff;

    assign w_word       = write_address[4:2];
    assign w_lane       = write_address[1:0];
    assign w_fill_valid = |r_fill_mask;
    assign w_tag_match  = w_fill_valid && (r_fill_tag == write_address[25:5]);
    assign w_fsm_idle   = (r_state == ST_IDLE);

    // A flush pulse outranks a same-cycle write, so the pulse itself stalls it too.
    assign write_stall = write_request &&
                         (flush || r_flush_pending || (w_fill_valid && !w_tag_match && !w_fsm_idle));
    assign w_accept    = write_request && !write_stall;

    assign w_timeout = (FLUSH_TIMEOUT != 0) && w_fill_valid && (r_timer == TW'(FLUSH_TIMEOUT));

    // The flush buffer only takes a new line while the burst engine is idle.
    assign w_handoff = w_fsm_idle && w_fill_valid &&
                       ((write_request && !w_tag_match) || r_flush_pending || w_timeout);

    assign idle      = !w_fill_valid && w_fsm_idle && !r_flush_pending;
    assign mem_write = mem_request;

    // Fill line tag and byte mask: cleared on handoff, a same-cycle write opens the new line
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_fill_tag  <= '0;
            r_fill_mask <= '0;
        end else begin
            if (w_handoff) begin
                r_fill_mask <= '0;
            end
            if (w_accept) begin
                if (w_handoff || !w_fill_valid) begin
                    r_fill_tag <= write_address[25:5];
                end
                r_fill_mask[w_word][w_lane] <= 1'b1;
            end
        end
    end

    // Fill line byte storage; masked-off bytes are don't-care so no reset is needed
    always_ff @(posedge clock) begin
        if (w_accept) begin
            r_fill_data[w_word][w_lane] <= write_data;
        end
    end

    // Snapshot of the fill line taken at handoff; outputs are gated by state so no reset is needed
    always_ff @(posedge clock) begin
        if (w_handoff) begin
            r_flush_tag  <= r_fill_tag;
            r_flush_data <= r_fill_data;
            r_flush_mask <= r_fill_mask;
        end
    end

    // Flush request latch and idle-cycle timeout counter
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_flush_pending <= 1'b0;
            r_timer         <= '0;
        end else begin
            if (flush && w_fill_valid && !w_handoff) begin
                r_flush_pending <= 1'b1;
            end else if (w_handoff || !w_fill_valid) begin
                r_flush_pending <= 1'b0;
            end

            // Saturates at the limit so an expiry seen while busy is taken on return to idle.
            if (w_handoff || w_accept || !w_fill_valid) begin
                r_timer <= '0;
            end else if ((FLUSH_TIMEOUT != 0) && (r_timer != TW'(FLUSH_TIMEOUT))) begin
                r_timer <= r_timer + 1'b1;
            end
        end
    end

    // Burst engine state and beat counter
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_beat  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_beat  <= w_beat_nxt;
        end
    end

    // Burst engine next state, beat advance and memory-side outputs
    always_comb begin
        w_state_nxt     = r_state;
        w_beat_nxt      = r_beat;
        mem_request     = 1'b0;
        mem_address     = '0;
        mem_wdata       = '0;
        mem_byte_enable = '0;
        case (r_state)
            ST_IDLE: begin
                w_beat_nxt = '0;
                if (w_handoff) begin
                    w_state_nxt = ST_REQ;
                end
            end
            ST_REQ: begin
                mem_request     = 1'b1;
                mem_address     = {r_flush_tag, 5'b0};
                // Beat 0 is presented early so an ack with wready can consume it.
                mem_wdata       = r_flush_data[0];
                mem_byte_enable = r_flush_mask[0];
                if (mem_ack) begin
                    w_state_nxt = ST_DATA;
                    w_beat_nxt  = mem_wready ? 4'd1 : 4'd0;
                end
            end
            ST_DATA: begin
                if (!r_beat[3]) begin
                    mem_wdata       = r_flush_data[r_beat[2:0]];
                    mem_byte_enable = r_flush_mask[r_beat[2:0]];
                    if (mem_wready) begin
                        w_beat_nxt = r_beat + 4'd1;
                    end
                end
                if (mem_complete) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_blit_write_buffer.sv
// Bench for blit_write_buffer: line-level scoreboard of expected bursts plus directed literal expectations.
// Latency: timeout, stall release and burst contents are pinned against hand-computed values.
// Backpressure: the memory responder varies ack delay, wready spacing and ack+wready overlap.
module tb_blit_write_buffer;

    localparam int TMO = 64;

    logic        clock = 1'b0;
    logic        reset;
    logic [25:0] write_address;
    logic [7:0]  write_data;
    logic        write_request;
    logic        write_stall;
    logic        flush;
    logic        idle;
    logic [25:0] mem_address;
    logic        mem_request;
    logic        mem_write;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_byte_enable;
    logic        mem_wready;
    logic        mem_ack;
    logic        mem_complete;

    blit_write_buffer #(.FLUSH_TIMEOUT(TMO)) dut (
        .clock(clock), .reset(reset),
        .write_address(write_address), .write_data(write_data),
        .write_request(write_request), .write_stall(write_stall),
        .flush(flush), .idle(idle),
        .mem_address(mem_address), .mem_request(mem_request), .mem_write(mem_write),
        .mem_wdata(mem_wdata), .mem_byte_enable(mem_byte_enable),
        .mem_wready(mem_wready), .mem_ack(mem_ack), .mem_complete(mem_complete)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    always @(posedge clock) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- line-level model ----------------
    typedef struct packed {
        logic [20:0]  tag;
        logic [255:0] data;
        logic [31:0]  mask;
    } line_t;

    line_t        exp_q[$];
    logic [25:0]  addr_log[$];
    logic [255:0] m_data;
    logic [31:0]  m_mask = '0;
    logic [20:0]  m_tag;
    int           m_idle = 0;

    int          burst_on = 0;
    int          mbeat = 0;
    int          n_done = 0;
    int          n_req = 0;
    int          done_cyc = 0;
    logic [31:0] cap_data [8];
    logic [3:0]  cap_be [8];
    line_t       cur;
    logic [3:0]  exp_be;
    logic [31:0] exp_w;
    logic [31:0] lm;
    int          off;

    task automatic model_close();
        line_t l;
        if (m_mask != 0) begin
            l.tag  = m_tag;
            l.data = m_data;
            l.mask = m_mask;
            exp_q.push_back(l);
        end
        m_mask = '0;
        m_idle = 0;
    endtask

    // Single compare process: updates the model from observed traffic and checks the memory side.
    always @(negedge clock) begin
        if (reset) begin
            exp_q.delete();
            m_mask   = '0;
            m_idle   = 0;
            burst_on = 0;
            mbeat    = 0;
        end else begin
            check("mem_write_follows_request", {31'd0, mem_write}, {31'd0, mem_request});
            if (!write_request) check("stall_without_request", {31'd0, write_stall}, 32'd0);

            if (mem_request) begin
                n_req++;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_burst: got address 0x%0h, expected no request", mem_address);
                end else begin
                    check("burst_address", {6'd0, mem_address}, {6'd0, exp_q[0].tag, 5'b0});
                end
            end

            // Model input side: lines close on flush, on a write to another line, or after TMO idle cycles.
            if (flush) begin
                model_close();
            end else if (write_request && !write_stall) begin
                if (m_mask != 0 && m_tag != write_address[25:5]) model_close();
                if (m_mask == 0) m_tag = write_address[25:5];
                off = int'(write_address[4:0]);
                m_data[8*off +: 8] = write_data;
                m_mask[off] = 1'b1;
                m_idle = 0;
            end else if (m_mask != 0) begin
                m_idle++;
                if (m_idle >= TMO) model_close();
            end

            // Memory side burst tracking
            if (mem_request && mem_ack) begin
                burst_on = 1;
                mbeat    = 0;
                addr_log.push_back(mem_address);
            end
            if (burst_on != 0 && mem_wready) begin
                if (mbeat < 8) begin
                    if (exp_q.size() > 0) begin
                        cur    = exp_q[0];
                        exp_be = cur.mask[4*mbeat +: 4];
                        exp_w  = cur.data[32*mbeat +: 32];
                        lm     = {{8{exp_be[3]}}, {8{exp_be[2]}}, {8{exp_be[1]}}, {8{exp_be[0]}}};
                        check("beat_byte_enable", {28'd0, mem_byte_enable}, {28'd0, exp_be});
                        check("beat_wdata", mem_wdata & lm, exp_w & lm);
                    end
                    cap_data[mbeat] = mem_wdata;
                    cap_be[mbeat]   = mem_byte_enable;
                    mbeat++;
                end else begin
                    check("byte_enable_after_8_beats", {28'd0, mem_byte_enable}, 32'd0);
                end
            end
            if (burst_on != 0 && mem_complete) begin
                check("beats_before_complete", mbeat, 8);
                if (exp_q.size() > 0) void'(exp_q.pop_front());
                burst_on = 0;
                n_done++;
                done_cyc = cyc;
            end
        end
    end

    // ---------------- memory responder ----------------
    int ack_delay = 1;
    int ack_wready = 0;
    int wready_gap = 0;
    int m_st = 0;
    int m_cnt = 0;
    int m_beats = 0;

    initial begin
        mem_ack = 1'b0;
        mem_wready = 1'b0;
        mem_complete = 1'b0;
        forever begin
            @(posedge clock);
            #1;
            mem_ack = 1'b0;
            mem_wready = 1'b0;
            mem_complete = 1'b0;
            if (reset) begin
                m_st = 0;
            end else begin
                if (m_st == 0 && mem_request) begin
                    m_st  = 1;
                    m_cnt = 0;
                end
                if (m_st == 1) begin
                    if (m_cnt >= ack_delay) begin
                        mem_ack = 1'b1;
                        m_st = 2;
                        m_cnt = 0;
                        m_beats = 0;
                        if (ack_wready != 0) begin
                            mem_wready = 1'b1;
                            m_beats = 1;
                        end
                    end else begin
                        m_cnt++;
                    end
                end else if (m_st == 2) begin
                    if (m_beats < 8) begin
                        if (m_cnt >= wready_gap) begin
                            mem_wready = 1'b1;
                            m_beats++;
                            m_cnt = 0;
                        end else begin
                            m_cnt++;
                        end
                    end else begin
                        // Stray wready alongside complete must be ignored by the DUT.
                        mem_complete = 1'b1;
                        mem_wready = 1'b1;
                        m_st = 0;
                    end
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    int acc_cyc = 0;

    task automatic do_write(input logic [25:0] a, input logic [7:0] d, output int stalls);
        write_address = a;
        write_data    = d;
        write_request = 1'b1;
        stalls = 0;
        @(negedge clock);
        while (write_stall && stalls < 1000) begin
            stalls++;
            @(negedge clock);
        end
        if (stalls >= 1000) begin
            n_checks++;
            n_errors++;
            $display("FAIL write_accept_timeout: got stall for %0d cycles at 0x%0h, expected acceptance", stalls, a);
        end
        acc_cyc = cyc;
        @(posedge clock);
        #1;
        write_request = 1'b0;
    endtask

    task automatic do_flush();
        flush = 1'b1;
        @(posedge clock);
        #1;
        flush = 1'b0;
    endtask

    task automatic wait_done(input int n);
        int k;
        k = 0;
        while (n_done < n && k < 3000) begin
            @(posedge clock);
            #1;
            k++;
        end
        check("burst_completed_in_time", {31'd0, n_done >= n}, 32'd1);
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no end of test, expected finish");
        $fatal(1, "watchdog expired");
    end

    int s;
    int n;
    int r0;

    initial begin
        reset = 1'b0;
        write_address = '0;
        write_data = '0;
        write_request = 1'b0;
        flush = 1'b0;
        #1 reset = 1'b1;

        // Reset values
        repeat (2) @(posedge clock);
        @(negedge clock);
        check("reset_idle", {31'd0, idle}, 32'd1);
        check("reset_mem_request", {31'd0, mem_request}, 32'd0);
        check("reset_mem_write", {31'd0, mem_write}, 32'd0);
        check("reset_mem_address", {6'd0, mem_address}, 32'd0);
        check("reset_mem_wdata", mem_wdata, 32'd0);
        check("reset_mem_be", {28'd0, mem_byte_enable}, 32'd0);
        check("reset_write_stall", {31'd0, write_stall}, 32'd0);
        @(posedge clock);
        #1 reset = 1'b0;
        tick(2);

        // Four bytes into word 0, then flush
        do_write(26'h100, 8'hAA, s);
        do_write(26'h101, 8'hBB, s);
        do_write(26'h102, 8'hCC, s);
        do_write(26'h103, 8'hDD, s);
        do_flush();
        wait_done(1);
        check("t1_address", {6'd0, addr_log[0]}, 32'h100);
        check("t1_beat0_wdata", cap_data[0], 32'hDDCCBBAA);
        check("t1_beat0_be", {28'd0, cap_be[0]}, 32'hF);
        for (int b = 1; b < 8; b++) check("t1_empty_beat_be", {28'd0, cap_be[b]}, 32'h0);
        check("t1_idle_after_complete", {31'd0, idle}, 32'd1);

        // Miss-triggered handoff without stall
        do_write(26'h104, 8'h5A, s);
        do_write(26'h200, 8'h77, s);
        check("t2_miss_no_stall", s, 0);
        wait_done(2);
        check("t2_address", {6'd0, addr_log[1]}, 32'h100);
        check("t2_beat1_be", {28'd0, cap_be[1]}, 32'h1);
        check("t2_beat1_byte", {24'd0, cap_data[1][7:0]}, 32'h5A);

        // Third line stalls while the drain is busy
        wready_gap = 4;
        do_write(26'h220, 8'h33, s);
        n = 0;
        while (!(burst_on != 0 && mbeat >= 1) && n < 500) begin
            tick(1);
            n++;
        end
        do_write(26'h300, 8'h44, s);
        check("t3_stall_seen", {31'd0, s > 0}, 32'd1);
        check("t3_stall_release_cycle", acc_cyc, done_cyc + 1);
        check("t3_bursts_done_at_release", n_done, 3);
        wready_gap = 0;
        do_flush();
        wait_done(5);
        check("t3_successor_address", {6'd0, addr_log[3]}, 32'h220);
        check("t3_last_address", {6'd0, addr_log[4]}, 32'h300);

        // Last write wins; flush beats a same-cycle write; ack with wready
        ack_wready = 1;
        do_write(26'h010, 8'h11, s);
        do_write(26'h010, 8'h22, s);
        write_address = 26'h011;
        write_data    = 8'h33;
        write_request = 1'b1;
        flush         = 1'b1;
        #1;
        check("t4_flush_stalls_write", {31'd0, write_stall}, 32'd1);
        @(posedge clock);
        #1;
        flush = 1'b0;
        write_request = 1'b0;
        wait_done(6);
        check("t4_address", {6'd0, addr_log[5]}, 32'h0);
        check("t4_beat4_byte", {24'd0, cap_data[4][7:0]}, 32'h22);
        check("t4_beat4_be", {28'd0, cap_be[4]}, 32'h1);
        check("t4_beat0_be", {28'd0, cap_be[0]}, 32'h0);
        ack_wready = 0;

        // Timeout flush latency, then flush on an empty buffer
        do_write(26'h040, 8'h99, s);
        n = 0;
        while (!mem_request && n < 200) begin
            @(posedge clock);
            #1;
            n++;
        end
        check("t5_timeout_latency", n, 65);
        wait_done(7);
        check("t5_address", {6'd0, addr_log[6]}, 32'h40);
        r0 = n_req;
        do_flush();
        tick(20);
        check("t5_empty_flush_no_burst", n_req, r0);
        check("t5_idle", {31'd0, idle}, 32'd1);

        // Reset during beat 3 abandons both lines
        do_write(26'h500, 8'h01, s);
        do_write(26'h520, 8'h02, s);
        wready_gap = 3;
        n = 0;
        while (!(burst_on != 0 && mbeat == 3) && n < 500) begin
            tick(1);
            n++;
        end
        #2 reset = 1'b1;
        #1;
        check("t6_reset_mem_request", {31'd0, mem_request}, 32'd0);
        check("t6_reset_idle", {31'd0, idle}, 32'd1);
        check("t6_reset_be", {28'd0, mem_byte_enable}, 32'd0);
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        wready_gap = 0;
        r0 = n_req;
        tick(150);
        check("t6_no_burst_after_reset", n_req, r0);
        check("t6_idle_after_reset", {31'd0, idle}, 32'd1);
        check("all_expected_bursts_seen", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
